// File: rtl/qoi_pkg.sv
// Shared QOI types, chunk tags, index hash and decoder FSM state, used by both
// the encoder and the decoder so the two sides cannot drift apart.
package qoi_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
  localparam logic [1:0] QOI_OP_INDEX = 2'b00;
  localparam logic [1:0] QOI_OP_DIFF  = 2'b01;
  localparam logic [1:0] QOI_OP_LUMA  = 2'b10;
  localparam logic [1:0] QOI_OP_RUN   = 2'b11;

  localparam rgba_t QOI_PREV_INIT = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_OPERAND,
    ST_RUN,
    ST_DONE
  } qoi_state_t;

  // Only the low 6 bits survive, so 8-bit wrapping products are sufficient.
  function automatic logic [5:0] qoi_hash(input rgba_t p);
    logic [7:0] s;
    s = p.r * 8'd3 + p.g * 8'd5 + p.b * 8'd7 + p.a * 8'd11;
    return s[5:0];
  endfunction

endpackage

// File: rtl/qoi_chunk_alu.sv
// Combinational pixel reconstruction for one QOI chunk from opcode, operands,
// previous pixel and index-table read; no state, no handshake.
module qoi_chunk_alu
  import qoi_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [31:0] operand,
  input  rgba_t       prev,
  input  rgba_t       index_px,
  output rgba_t       px
);

  logic [7:0] dg;
  logic [7:0] luma_b;

  always_comb begin
    luma_b = operand[7:0];
    dg     = {2'b00, opcode[5:0]} - 8'd32;
    px     = prev;
    if (opcode == QOI_OP_RGB) begin
      px = '{r: operand[23:16], g: operand[15:8], b: operand[7:0], a: prev.a};
    end else if (opcode == QOI_OP_RGBA) begin
      px = operand;
    end else begin
      case (opcode[7:6])
        QOI_OP_INDEX: px = index_px;
        QOI_OP_DIFF: begin
          px.r = prev.r + {6'd0, opcode[5:4]} - 8'd2;
          px.g = prev.g + {6'd0, opcode[3:2]} - 8'd2;
          px.b = prev.b + {6'd0, opcode[1:0]} - 8'd2;
        end
        QOI_OP_LUMA: begin
          px.r = prev.r + dg + {4'd0, luma_b[7:4]} - 8'd8;
          px.g = prev.g + dg;
          px.b = prev.b + dg + {4'd0, luma_b[3:0]} - 8'd8;
        end
        default: px = prev;
      endcase
    end
  end

endmodule

// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: one pixel on the edge accepting a chunk's last byte.
// Byte input stalls while the pixel register is full and not being drained.
module qoi_decoder
  import qoi_pkg::*;
#(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] px_out,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        done,
  output logic        overrun
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);

  qoi_state_t    state;
  rgba_t         prev;
  rgba_t         index_tbl [64];
  logic [7:0]    op_reg;
  logic [23:0]   opnd_sr;
  logic [2:0]    opnd_left;
  logic [5:0]    run_left;
  logic [CW-1:0] pix_cnt;

  logic        slot_free;
  logic        accept;
  logic        produce;
  logic        last_pix;
  logic [5:0]  run_rem;
  logic [7:0]  alu_op;
  logic [31:0] alu_operand;
  rgba_t       alu_px;

  assign slot_free  = !px_valid || px_ready;
  assign byte_ready = !reset && !done && slot_free &&
                      (state == ST_OPCODE || state == ST_OPERAND);
  assign accept     = byte_valid && byte_ready;
  assign last_pix   = (pix_cnt == CW'(NPIX - 1));

  // In RUN the held opcode is the run tag, so the ALU simply returns prev.
  assign alu_op      = (state == ST_OPCODE) ? byte_in : op_reg;
  assign alu_operand = {opnd_sr, byte_in};

  // run_rem is the number of pixels still owed after the one produced now.
  always_comb begin
    produce = 1'b0;
    run_rem = '0;
    case (state)
      ST_OPCODE: begin
        if (accept && byte_in != QOI_OP_RGB && byte_in != QOI_OP_RGBA &&
            byte_in[7:6] != QOI_OP_LUMA) begin
          produce = 1'b1;
          if (byte_in[7:6] == QOI_OP_RUN) run_rem = byte_in[5:0];
        end
      end
      ST_OPERAND: produce = accept && (opnd_left == 3'd1);
      ST_RUN: begin
        produce = slot_free;
        run_rem = run_left - 6'd1;
      end
      default: produce = 1'b0;
    endcase
  end

  qoi_chunk_alu u_alu (
    .opcode   (alu_op),
    .operand  (alu_operand),
    .prev     (prev),
    .index_px (index_tbl[alu_op[5:0]]),
    .px       (alu_px)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_OPCODE;
      prev      <= QOI_PREV_INIT;
      for (int i = 0; i < 64; i++) index_tbl[i] <= '0;
      op_reg    <= '0;
      opnd_sr   <= '0;
      opnd_left <= '0;
      run_left  <= '0;
      pix_cnt   <= '0;
      px_out    <= '0;
      px_valid  <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else if (start) begin
      state     <= ST_OPCODE;
      prev      <= QOI_PREV_INIT;
      for (int i = 0; i < 64; i++) index_tbl[i] <= '0;
      op_reg    <= '0;
      opnd_sr   <= '0;
      opnd_left <= '0;
      run_left  <= '0;
      pix_cnt   <= '0;
      px_out    <= '0;
      px_valid  <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (px_valid && px_ready) px_valid <= 1'b0;

      if (accept && state == ST_OPCODE) begin
        op_reg <= byte_in;
        if (byte_in == QOI_OP_RGB) begin
          state     <= ST_OPERAND;
          opnd_left <= 3'd3;
        end else if (byte_in == QOI_OP_RGBA) begin
          state     <= ST_OPERAND;
          opnd_left <= 3'd4;
        end else if (byte_in[7:6] == QOI_OP_LUMA) begin
          state     <= ST_OPERAND;
          opnd_left <= 3'd1;
        end else if (byte_in[7:6] == QOI_OP_RUN && byte_in[5:0] != 6'd0) begin
          state    <= ST_RUN;
          run_left <= byte_in[5:0];
        end
      end

      if (accept && state == ST_OPERAND) begin
        opnd_sr   <= {opnd_sr[15:0], byte_in};
        opnd_left <= opnd_left - 3'd1;
        if (opnd_left == 3'd1) state <= ST_OPCODE;
      end

      if (produce && state == ST_RUN) begin
        run_left <= run_rem;
        if (run_rem == 6'd0) state <= ST_OPCODE;
      end

      if (produce) begin
        px_out                      <= alu_px;
        px_valid                    <= 1'b1;
        prev                        <= alu_px;
        index_tbl[qoi_hash(alu_px)] <= alu_px;
        pix_cnt                     <= pix_cnt + 1'b1;
        // Frame end wins over any state chosen above; leftover run pixels are dropped.
        if (last_pix) begin
          done  <= 1'b1;
          state <= ST_DONE;
          if (run_rem != 6'd0) overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed and randomized checks of qoi_decoder against a chunk-level reference decoder.
module tb_qoi_decoder;

  localparam int W    = 40;
  localparam int H    = 30;
  localparam int NPIX = W * H;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] px_out;
  logic        px_valid;
  logic        px_ready;
  logic        done;
  logic        overrun;

  logic        byte_valid_s;
  logic        byte_ready_s;
  logic [31:0] px_out_s;
  logic        px_valid_s;
  logic        done_s;
  logic        overrun_s;

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  logic        exp_ovr;

  qoi_decoder #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .px_out(px_out), .px_valid(px_valid), .px_ready(px_ready),
    .done(done), .overrun(overrun)
  );

  qoi_decoder #(.WIDTH(2), .HEIGHT(2)) dut_s (
    .clk(clk), .reset(reset), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid_s), .byte_ready(byte_ready_s),
    .px_out(px_out_s), .px_valid(px_valid_s), .px_ready(px_ready),
    .done(done_s), .overrun(overrun_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    #1;
    while (!byte_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("send_byte_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic expect_px(input string tag, input logic [31:0] expv);
    int n;
    n = 0;
    #1;
    while (!px_valid && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({tag, "_valid"}, px_valid, 1'b1);
    chk(tag, px_out, expv);
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the chunk stream with plain integer arithmetic, frame-truncated.
  task automatic run_model();
    int r, g, b, a, pr, pg, pb, pa, i, n, reps, dg, b2;
    logic [31:0] idx [64];
    logic [31:0] px;
    logic [7:0]  op;
    for (int k = 0; k < 64; k++) idx[k] = '0;
    pr = 0; pg = 0; pb = 0; pa = 255;
    i = 0; n = 0;
    exp_q.delete();
    exp_ovr = 1'b0;
    while (i < stim_q.size() && n < NPIX) begin
      op = stim_q[i];
      i++;
      reps = 1;
      r = pr; g = pg; b = pb; a = pa;
      if (op == 8'hFE) begin
        r = int'(stim_q[i]); g = int'(stim_q[i+1]); b = int'(stim_q[i+2]);
        i += 3;
      end else if (op == 8'hFF) begin
        r = int'(stim_q[i]); g = int'(stim_q[i+1]); b = int'(stim_q[i+2]); a = int'(stim_q[i+3]);
        i += 4;
      end else if (op[7:6] == 2'd0) begin
        px = idx[op[5:0]];
        r = int'(px[31:24]); g = int'(px[23:16]); b = int'(px[15:8]); a = int'(px[7:0]);
      end else if (op[7:6] == 2'd1) begin
        r = (pr + int'(op[5:4]) - 2) & 255;
        g = (pg + int'(op[3:2]) - 2) & 255;
        b = (pb + int'(op[1:0]) - 2) & 255;
      end else if (op[7:6] == 2'd2) begin
        dg = int'(op[5:0]) - 32;
        b2 = int'(stim_q[i]);
        i++;
        r = (pr + dg + (b2 >> 4) - 8) & 255;
        g = (pg + dg) & 255;
        b = (pb + dg + (b2 & 15) - 8) & 255;
      end else begin
        reps = int'(op[5:0]) + 1;
      end
      px = {r[7:0], g[7:0], b[7:0], a[7:0]};
      for (int k = 0; k < reps; k++) begin
        if (n < NPIX) begin
          exp_q.push_back(px);
          n++;
        end else begin
          exp_ovr = 1'b1;
        end
      end
      pr = r; pg = g; pb = b; pa = a;
      idx[(r * 3 + g * 5 + b * 7 + a * 11) % 64] = px;
    end
  endtask

  initial begin
    int hs, cnt, bi, pi, cyc, npx, kind, rl;
    logic acc, take;

    reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    byte_valid_s = 1'b0; px_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_px_out", px_out, 32'h0);
    chk("rst_px_valid", px_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_byte_ready", byte_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_byte_ready", byte_ready, 1'b1);
    @(posedge clk);
    #1;

    // RGB then INDEX hit at hash 21
    send_byte(8'hFE); send_byte(8'h10); send_byte(8'h20);
    chk("rgb_not_yet", px_valid, 1'b0);
    send_byte(8'h30);
    chk("rgb_latency", px_valid, 1'b1);
    expect_px("rgb_px", 32'h102030FF);
    send_byte(8'h15);
    expect_px("index_px", 32'h102030FF);

    // DIFF with wrap
    do_reset();
    send_byte(8'h7F);
    expect_px("diff_up", 32'h010101FF);
    send_byte(8'h40);
    expect_px("diff_wrap", 32'hFFFFFFFF);

    // LUMA
    do_reset();
    send_byte(8'hA8);
    chk("luma_not_yet", px_valid, 1'b0);
    send_byte(8'h8F);
    chk("luma_latency", px_valid, 1'b1);
    chk("luma_px", px_out, 32'h08080FFF);
    @(posedge clk);
    #1;

    // RUN of 4 under toggling px_ready
    do_reset();
    send_byte(8'hFE); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    expect_px("run_seed", 32'h112233FF);
    byte_valid = 1'b1; byte_in = 8'hC3;
    #1;
    chk("run_accept", byte_ready, 1'b1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    hs = 0;
    for (int k = 0; k < 10; k++) begin
      px_ready = (k % 2 == 0);
      #1;
      chk("run_bready", byte_ready, (hs == 4) || (hs == 3 && px_ready));
      chk("run_valid", px_valid, hs < 4);
      if (px_valid) chk("run_px", px_out, 32'h112233FF);
      if (px_valid && px_ready) hs++;
      @(posedge clk);
      #1;
    end
    chk("run_count", hs, 4);
    px_ready = 1'b1;

    // start discards partial chunk and clears the index table
    send_byte(8'hFE); send_byte(8'h10);
    pulse_start();
    chk("start_px_valid", px_valid, 1'b0);
    send_byte(8'h7F);
    expect_px("start_fresh", 32'h010101FF);
    send_byte(8'h15);
    expect_px("start_index_clear", 32'h00000000);

    // async reset drops px_valid immediately, then aborts a partial chunk
    px_ready = 1'b0;
    send_byte(8'h7F);
    #1;
    chk("arst_pre_valid", px_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_px_valid", px_valid, 1'b0);
    chk("arst_px_out", px_out, 32'h0);
    chk("arst_byte_ready", byte_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_rel_ready", byte_ready, 1'b1);
    @(posedge clk);
    #1;
    px_ready = 1'b1;
    send_byte(8'hFE); send_byte(8'h10);
    do_reset();
    send_byte(8'h7F);
    expect_px("arst_fresh", 32'h010101FF);

    // 2x2 frame: run of 6 overruns
    do_reset();
    byte_valid_s = 1'b1; byte_in = 8'hC5;
    #1;
    chk("small_accept", byte_ready_s, 1'b1);
    @(posedge clk);
    #1;
    byte_valid_s = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (px_valid_s) begin
        cnt++;
        chk("small_px", px_out_s, 32'h000000FF);
      end
      @(posedge clk);
      #1;
    end
    chk("small_count", cnt, 4);
    chk("small_done", done_s, 1'b1);
    chk("small_overrun", overrun_s, 1'b1);
    byte_valid_s = 1'b1; byte_in = 8'h7F;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("small_blocked", byte_ready_s, 1'b0);
      chk("small_no_px", px_valid_s, 1'b0);
      @(posedge clk);
      #1;
    end
    byte_valid_s = 1'b0;

    // Random full frame against the reference model
    stim_q.delete();
    npx = 0;
    while (npx < NPIX) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          stim_q.push_back(8'hFE);
          for (int k = 0; k < 3; k++) stim_q.push_back(8'($urandom));
          npx++;
        end
        1: begin
          stim_q.push_back(8'hFF);
          for (int k = 0; k < 4; k++) stim_q.push_back(8'($urandom));
          npx++;
        end
        2: begin stim_q.push_back({2'b00, 6'($urandom)}); npx++; end
        3: begin stim_q.push_back({2'b01, 6'($urandom)}); npx++; end
        4: begin
          stim_q.push_back({2'b10, 6'($urandom)});
          stim_q.push_back(8'($urandom));
          npx++;
        end
        default: begin
          rl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 61) : $urandom_range(0, 12);
          stim_q.push_back({2'b11, 6'(rl)});
          npx += rl + 1;
        end
      endcase
    end
    run_model();
    do_reset();
    bi = 0; pi = 0; cyc = 0;
    while ((bi < stim_q.size() || pi < exp_q.size()) && cyc < 40000) begin
      byte_valid = (bi < stim_q.size()) && ($urandom_range(0, 3) != 0);
      byte_in    = (bi < stim_q.size()) ? stim_q[bi] : 8'h00;
      px_ready   = ($urandom_range(0, 3) != 0);
      #1;
      acc  = byte_valid && byte_ready;
      take = px_valid && px_ready;
      if (take) begin
        if (pi < exp_q.size()) chk("rand_px", px_out, exp_q[pi]);
        else chk("rand_extra_px", 32'(pi), 32'(exp_q.size()));
        pi++;
      end
      if (acc) bi++;
      @(posedge clk);
      #1;
      cyc++;
    end
    byte_valid = 1'b0;
    px_ready   = 1'b1;
    chk("rand_bytes_used", 32'(bi), 32'(stim_q.size()));
    chk("rand_px_count", 32'(pi), 32'(exp_q.size()));
    repeat (3) @(posedge clk);
    #1;
    chk("rand_done", done, 1'b1);
    chk("rand_overrun", overrun, exp_ovr);
    chk("rand_done_blocks", byte_ready, 1'b0);
    chk("rand_idle_valid", px_valid, 1'b0);
    pulse_start();
    chk("start_clr_done", done, 1'b0);
    chk("start_clr_overrun", overrun, 1'b0);
    chk("start_ready", byte_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qoi_decoder.md
# qoi_decoder

Streaming QOI chunk decoder: consumes the headerless, marker-free chunk byte stream produced by the team's `qoi` encoder and regenerates one `WIDTH`×`HEIGHT` frame of `rgba_t` pixels in raster order. Sits at the verification/readback end of the debayer→QOI path, for example behind the SPI byte loopback. It checks encoder output in hardware and feeds a display or compare stage. Byte input and pixel output both use valid/ready handshakes.

## Interface
- `WIDTH`, 40, pixels per row
- `HEIGHT`, 30, rows per frame
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  synchronous one-cycle pulse; discards any partial chunk and restarts frame context
- `byte_in`  in  8  chunk byte
- `byte_valid`  in  1  `byte_in` is valid
- `byte_ready`  out  1  decoder accepts `byte_in` this cycle
- `px_out`  out  32  decoded `rgba_t` pixel
- `px_valid`  out  1  `px_out` is valid
- `px_ready`  in  1  downstream accepts `px_out`
- `done`  out  1  sticky; `WIDTH*HEIGHT` pixels have been accepted
- `overrun`  out  1  sticky; a RUN chunk extended past the frame end

## Operation
- Context is `prev`, initialised to {00,00,00,FF}, plus `index[64]`, all zero. Both are restored by `reset` or `start`. The pixel counter clears to 0 at the same time.
- A byte transfers when `byte_valid && byte_ready`. `byte_ready` = state ∈ {OPCODE, OPERAND} && !done && (!px_valid || px_ready).
- FSM states and transitions:
  - OPCODE: decode the tag. 0xFE leads to OPERAND for 3 bytes (RGB, alpha kept from `prev`). 0xFF leads to OPERAND for 4 bytes (RGBA). 0xFE/0xFF take precedence over the `11` tag.
  - `00iiiiii` INDEX: pixel = `index[i]`.
  - `01rrggbb` DIFF: each channel = prev + field − 2.
  - `10gggggg` LUMA: leads to OPERAND for 1 byte.
  - `11nnnnnn` RUN: leads to RUN with n+1 pixels equal to `prev`.
  - OPERAND: collect operand bytes MSB-first (r,g,b[,a]). After the last byte, produce the pixel and return to OPCODE.
  - LUMA arithmetic: dg = g6 − 32. r = prev.r + dg + (hi4 − 8). g = prev.g + dg. b = prev.b + dg + (lo4 − 8).
  - RUN: load one pixel per output handshake. Return to OPCODE when the count is exhausted.
- All channel arithmetic is modulo 256 (8-bit wrap). There is no saturation.
- Producing a pixel does all of the following on the same edge:
  - registers it into `px_out` and sets `px_valid`
  - sets `prev` to the pixel
  - writes `index[(r*3+g*5+b*7+a*11) mod 64]` to the pixel
  - increments the pixel count
- When the count reaches `WIDTH*HEIGHT`, the decoder sets `done` and goes to DONE:
  - `byte_ready` stays 0 and further bytes are not consumed.
  - If a RUN still had pixels remaining, it sets `overrun` and drops the remainder.
- `start` has priority over every other action in its cycle and clears `done`/`overrun`. `px_valid` drops.

## Timing
- Reset values:
  - `px_out` = 0, `px_valid` = 0, `done` = 0, `overrun` = 0.
  - `byte_ready` = 0 while `reset` is high, and 1 in the first cycle after release.
- Latency: `px_valid` rises on the edge that accepts the final byte of a chunk. That is 1 cycle for INDEX/DIFF/RUN-first-pixel and for the LUMA 2nd byte, RGB 4th byte, RGBA 5th byte.
- Throughput: 1 pixel/cycle for single-byte chunks and RUN when `px_ready` is held high.
- `px_out`/`px_valid` hold steady while `px_valid && !px_ready`.
- `byte_ready` is combinational from state and `px_ready`. There is no combinational path from `byte_valid` to `byte_ready`.
- An INDEX read observes the write from the immediately preceding pixel. The table is a register array written on the producing edge, so no bypass is needed.
- An asynchronous `reset` mid-chunk aborts it. `px_valid` drops immediately.

## Structure
- Shared `qoi_pkg` holds:
  - `rgba_t`
  - tag constants QOI_OP_RGB=8'hFE, QOI_OP_RGBA=8'hFF, 2-bit INDEX/DIFF/LUMA/RUN tags
  - function `qoi_hash(rgba_t)` → 6 bits
  - the FSM state enum
- The encoder is to import the same package.
- Sub-module `qoi_chunk_alu` is combinational. It takes the opcode, operand bytes, `prev` and the `index` read, and returns the pixel. The FSM, handshake, counter and index table stay in `qoi_decoder`.

## Test plan
- After reset, bytes FE 10 20 30 then 15 → pixels {10,20,30,FF} and {10,20,30,FF}. The second is the INDEX hit at hash 21.
- From reset, bytes 7F then 40 → {01,01,01,FF} then {FF,FF,FF,FF}, which exercises the wrap.
- From reset, bytes A8 8F → {08,08,0F,FF}. `px_valid` rises on the edge accepting 8F.
- After one RGB pixel, byte C3 with `px_ready` toggling 1,0,1,0… → exactly 4 identical pixels. `byte_ready` = 0 until the 4th handshake, and `px_out` stays stable during stalls.
- With WIDTH=2, HEIGHT=2, from reset, byte C5 → 4 pixels {00,00,00,FF}, then `done`=1 and `overrun`=1. A following byte 7F is never accepted (`byte_ready`=0).
- After accepting FE 10, pulse `start`, then send 7F → {01,01,01,FF}. The partial chunk is discarded and the context is fresh. Repeat with async `reset` → same result.
